// File: rtl/pcs_tx_gearbox_sched.sv
// pcs_tx_gearbox_sched
//   Schedules the 64b/66b encoder into the 66b -> DATA_WIDTH TX gearbox.
//   Every gearbox sequence of SEQ_CYCLES words holds back the encoder for
//   one 64-bit block worth of words (PAUSE_CYCLES), giving the gearbox room
//   to emit the sync headers it has accumulated. The block tracks the word
//   position in the sequence and the word phase inside a block. It checks
//   that encoder valids arrive exactly ENC_LATENCY cycles after the ready it
//   was given, and counts qualified encoding errors.
//
// Ports
//   i_clk                 core clock
//   i_reset_n             asynchronous active-low reset
//   i_enable              level; run the TX schedule while high
//   i_gb_ready            gearbox accepts a word this cycle
//   o_scrambler_trdy      ready to the encoder (combinational)
//   i_encoded_data_valid  encoder output valid
//   i_encoding_err        encoder error flag, qualified by valid
//   i_clear_stats         one-cycle pulse clearing o_align_err / o_err_cnt
//   o_seq_cnt             gearbox sequence position 0..SEQ_CYCLES-1
//   o_hdr_slot            accepted word is the first word of a block
//   o_busy                FSM is not idle
//   o_align_err           sticky schedule/alignment violation
//   o_err_cnt             saturating count of qualified encoding errors
module pcs_tx_gearbox_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int HDR_WIDTH   = 2,
  parameter int ENC_LATENCY = 2,
  parameter int ERR_CNT_W   = 16,
  localparam int WPB          = 64 / DATA_WIDTH,
  localparam int SEQ_CYCLES   = (32 * (64 + HDR_WIDTH)) / DATA_WIDTH,
  localparam int PAUSE_CYCLES = WPB,
  localparam int CNT_W        = $clog2(SEQ_CYCLES)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_gb_ready,
  output logic                 o_scrambler_trdy,
  input  logic                 i_encoded_data_valid,
  input  logic                 i_encoding_err,
  input  logic                 i_clear_stats,
  output logic [CNT_W-1:0]     o_seq_cnt,
  output logic                 o_hdr_slot,
  output logic                 o_busy,
  output logic                 o_align_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int PH_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [CNT_W-1:0] PAUSE_START = CNT_W'(SEQ_CYCLES - PAUSE_CYCLES);
  localparam logic [CNT_W-1:0] SEQ_LAST    = CNT_W'(SEQ_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(WPB - 1);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("pcs_tx_gearbox_sched: DATA_WIDTH must be 32 or 64");
  end
  if (ENC_LATENCY < 1) begin : g_bad_latency
    $error("pcs_tx_gearbox_sched: ENC_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       seq_cnt_q, seq_cnt_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [ENC_LATENCY-1:0] trdy_hist_q, trdy_hist_d;
  logic                   align_err_q, align_err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic active;
  logic counting;
  logic trdy;
  logic trdy_dly;
  logic split_err;
  logic valid_err;
  logic enc_err;

  // DRAIN keeps feeding the encoder only to finish a partially sent block.
  assign active    = (state_q == RUN) || ((state_q == DRAIN) && (phase_q != '0));
  assign counting  = ((state_q == RUN) || (state_q == DRAIN)) && i_gb_ready;
  assign trdy      = active && i_gb_ready && (seq_cnt_q < PAUSE_START);
  assign trdy_dly  = trdy_hist_q[ENC_LATENCY-1];
  // Reaching the pause window mid-block would split a block across the pause.
  assign split_err = counting && (seq_cnt_q == PAUSE_START) && (phase_q != '0);
  assign valid_err = i_encoded_data_valid && !trdy_dly;
  assign enc_err   = i_encoded_data_valid && i_encoding_err;

  always_comb begin
    seq_cnt_d = seq_cnt_q;
    phase_d   = phase_q;
    if (state_q == START) begin
      seq_cnt_d = '0;
      phase_d   = '0;
    end
    // Pause slots still consume gearbox cycles, so the count runs on gb_ready.
    if (counting) begin
      seq_cnt_d = (seq_cnt_q == SEQ_LAST) ? '0 : seq_cnt_q + CNT_W'(1);
    end
    if (trdy) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end
  end

  // Ready history: bit i holds trdy from i+1 cycles ago.
  always_comb begin
    trdy_hist_d    = '0;
    trdy_hist_d[0] = trdy;
    for (int i = 1; i < ENC_LATENCY; i++) begin
      trdy_hist_d[i] = trdy_hist_q[i-1];
    end
  end

  // Clear has priority over a same-cycle error set or increment.
  always_comb begin
    align_err_d = align_err_q || valid_err || split_err;
    err_cnt_d   = err_cnt_q;
    if (enc_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
    if (i_clear_stats) begin
      align_err_d = 1'b0;
      err_cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      seq_cnt_q   <= '0;
      phase_q     <= '0;
      trdy_hist_q <= '0;
      align_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE:    if (i_enable) state_q <= START;
        START:   state_q <= RUN;
        RUN:     if (!i_enable) state_q <= DRAIN;
        DRAIN:   if (phase_q == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      seq_cnt_q   <= seq_cnt_d;
      phase_q     <= phase_d;
      trdy_hist_q <= trdy_hist_d;
      align_err_q <= align_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_scrambler_trdy = trdy;
  assign o_seq_cnt        = seq_cnt_q;
  assign o_hdr_slot       = trdy && (phase_q == '0);
  assign o_busy           = (state_q != IDLE);
  assign o_align_err      = align_err_q;
  assign o_err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_pcs_tx_gearbox_sched.sv
// Testbench for pcs_tx_gearbox_sched (DATA_WIDTH=32, ENC_LATENCY=2, ERR_CNT_W=16).
module tb_pcs_tx_gearbox_sched;

  localparam int DW       = 32;
  localparam int LAT      = 2;
  localparam int EW       = 16;
  localparam int SEQ      = 66;
  localparam int PAUSE_AT = 64;
  localparam int CW       = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, gb = 1'b0, vld = 1'b0, err = 1'b0, clr = 1'b0;
  logic          trdy, hdr, busy, align;
  logic [CW-1:0] seq;
  logic [EW-1:0] ecnt;

  int checks = 0;
  int errors = 0;
  int k = 0;        // words accepted in RUN since the last START
  int exp_cnt = 0;  // expected error count
  logic h1 = 1'b0, h2 = 1'b0;

  typedef struct {
    logic          trdy;
    logic [CW-1:0] seq;
    logic          hdr;
    logic [EW-1:0] cnt;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic          rst_n, en, gb;
    logic          exp_trdy;
    logic [CW-1:0] exp_seq;
    logic          exp_hdr, exp_busy;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  pcs_tx_gearbox_sched #(
    .DATA_WIDTH(DW), .HDR_WIDTH(2), .ENC_LATENCY(LAT), .ERR_CNT_W(EW)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_enable(en),
    .i_gb_ready(gb),
    .o_scrambler_trdy(trdy),
    .i_encoded_data_valid(vld),
    .i_encoding_err(err),
    .i_clear_stats(clr),
    .o_seq_cnt(seq),
    .o_hdr_slot(hdr),
    .o_busy(busy),
    .o_align_err(align),
    .o_err_cnt(ecnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic e, input logic g, input logic v, input logic r, input logic c);
    @(posedge clk);
    #1;
    en = e; gb = g; vld = v; err = r; clr = c;
    @(negedge clk);
  endtask

  // Runs n cycles with enable high; the encoder side answers each ready
  // with a valid LAT cycles later and a random error flag.
  task automatic run(input int n, input logic g);
    exp_t x, y;
    logic v, r;
    h1 = 1'b0; h2 = 1'b0;
    for (int i = 0; i < n; i++) begin
      x.trdy = g && ((k % SEQ) < PAUSE_AT);
      x.seq  = CW'(k % SEQ);
      x.hdr  = x.trdy && ((k % 2) == 0);
      x.cnt  = EW'(exp_cnt);
      sbq.push_back(x);
      v = h2;
      r = v && ($urandom_range(0, 1) == 1);
      cyc(1'b1, g, v, r, 1'b0);
      y = sbq.pop_front();
      chk("run_trdy", trdy, y.trdy);
      chk("run_seq", seq, y.seq);
      chk("run_hdr", hdr, y.hdr);
      chk("run_errcnt", ecnt, y.cnt);
      chk("run_align", align, 1'b0);
      if (v && r && exp_cnt < 65535) exp_cnt++;
      h2 = h1;
      h1 = x.trdy;
      if (g) k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    // rst_n en gb | trdy seq hdr busy
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0};  // IDLE sees enable
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1};  // START
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 1'b1, 1'b1};  // RUN, first word
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 7'd1, 1'b0, 1'b1};

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      rst_n = vt[i].rst_n; en = vt[i].en; gb = vt[i].gb;
      vld = 1'b0; err = 1'b0; clr = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_trdy", i), trdy, vt[i].exp_trdy);
      chk($sformatf("vec%0d_seq", i), seq, vt[i].exp_seq);
      chk($sformatf("vec%0d_hdr", i), hdr, vt[i].exp_hdr);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
      chk($sformatf("vec%0d_align", i), align, 1'b0);
      chk($sformatf("vec%0d_errcnt", i), ecnt, 0);
    end
    k = 2;

    // Continuous run: pause at 64,65, wrap 65->0.
    run(200, 1'b1);

    // Freeze at seq 11 (phase 1) for 3 cycles, then continue past the pause.
    run((11 - (k % SEQ) + SEQ) % SEQ, 1'b1);
    run(3, 1'b0);
    run(70, 1'b1);

    // Enable dropped while the block's first word is sent: DRAIN sends one more.
    run((20 - (k % SEQ) + SEQ) % SEQ, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dropA_trdy0", trdy, 1'b1);
    chk("dropA_hdr0", hdr, 1'b1);
    chk("dropA_seq0", seq, 7'd20);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dropA_drain_trdy", trdy, 1'b1);
    chk("dropA_drain_hdr", hdr, 1'b0);
    chk("dropA_drain_seq", seq, 7'd21);
    chk("dropA_drain_busy", busy, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dropA_last_trdy", trdy, 1'b0);
    chk("dropA_last_busy", busy, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dropA_idle_busy", busy, 1'b0);
    chk("dropA_idle_trdy", trdy, 1'b0);

    // Enable dropped on a block's last word: 1-cycle DRAIN, re-enable ignored there.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dropB_idle_busy", busy, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dropB_start_busy", busy, 1'b1);
    chk("dropB_start_trdy", trdy, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dropB_run_seq", seq, 7'd0);
    chk("dropB_run_hdr", hdr, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dropB_last_trdy", trdy, 1'b1);
    chk("dropB_last_hdr", hdr, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dropB_drain_trdy", trdy, 1'b0);
    chk("dropB_drain_busy", busy, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dropB_idle_busy", busy, 1'b0);
    chk("dropB_idle_trdy", trdy, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_start_busy", busy, 1'b1);
    chk("restart_start_trdy", trdy, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_trdy", trdy, 1'b1);
    chk("restart_seq", seq, 7'd0);
    chk("restart_hdr", hdr, 1'b1);
    k = 1;

    // Valid two cycles after the trdy=0 slot at seq 64.
    run((64 - (k % SEQ) + SEQ) % SEQ, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pause64_trdy", trdy, 1'b0);
    chk("pause64_seq", seq, 7'd64);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pause65_trdy", trdy, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bad_valid_same_cycle", align, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("align_set", align, 1'b1);
    chk("errcnt_before_clear", ecnt, EW'(exp_cnt));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("align_sticky", align, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("align_during_clear", align, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("align_cleared", align, 1'b0);
    chk("errcnt_cleared", ecnt, 0);
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_after_clear", busy, 1'b0);

    // Saturation: 70000 qualified errors.
    for (int i = 0; i < 70000; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("errcnt_saturated", ecnt, 16'hFFFF);
    chk("align_idle_valid", align, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("errcnt_before_clear_edge", ecnt, 16'hFFFF);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("errcnt_clear_wins", ecnt, 0);
    chk("align_clear_wins", align, 1'b0);

    // Asynchronous reset at seq 40.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 41; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_reset_seq", seq, 7'd40);
    chk("pre_reset_errcnt", ecnt, 1);
    chk("pre_reset_align", align, 1'b1);
    chk("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("areset_trdy", trdy, 1'b0);
    chk("areset_seq", seq, 7'd0);
    chk("areset_hdr", hdr, 1'b0);
    chk("areset_busy", busy, 1'b0);
    chk("areset_align", align, 1'b0);
    chk("areset_errcnt", ecnt, 0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", busy, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_reset_start_busy", busy, 1'b1);
    chk("post_reset_start_trdy", trdy, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_reset_trdy", trdy, 1'b1);
    chk("post_reset_seq", seq, 7'd0);
    chk("post_reset_hdr", hdr, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
